fd_segment_tester: RTL and testbench
====================================

FD_SEGMENT_TESTER -- requirements
Module: fd_segment_tester

Interface
REQ-001 Parameter THRESHOLD, default 8'd20, FAST intensity threshold t.
REQ-002 Parameter IMG_WIDTH, default 177, image row pitch in pixels; fixes the circle offsets.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 nReset  in  1  reset, asynchronous, active-low.
REQ-005 refAddr  in  15  address of the candidate (centre) pixel.
REQ-006 adjNumber  in  5  fetch index; 0 = centre, 1..16 = circle pixels; values >16 mean no fetch.
REQ-007 regAddr  in  5  register-file write slot, lags adjNumber by 2 cycles; values >16 mean no write.
REQ-008 readen  in  1  one-cycle pulse: all 17 slots are loaded, evaluate.
REQ-009 memAddr  out  15  registered pixel-memory read address.
REQ-010 memRd  out  1  registered read strobe for memAddr.
REQ-011 memData  in  8  pixel data from synchronous memory, valid the cycle after memAddr/memRd.
REQ-012 cornerValid  out  1  one-cycle result strobe.
REQ-013 cornerFlag  out  1  1 = candidate is a FAST-9 corner; valid with cornerValid.
REQ-014 cornerAddr  out  15  refAddr captured at readen; valid with cornerValid.
REQ-015 overrun  out  1  sticky: readen arrived while not IDLE.

Function
REQ-016 Each cycle with adjNumber<=16, memAddr SHALL load refAddr+off[adjNumber] modulo 2^15 and memRd SHALL be 1; otherwise memRd SHALL be 0 and memAddr SHALL hold.
REQ-017 off[0]=0; off[1..16] SHALL be (dx,dy)=(0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3), off=dy*IDLE_WIDTH... i.e. dy*IMG_WIDTH+dx (W=177: -531,-530,-352,-174,+3,+180,+356,+532,+531,+530,+352,+174,-3,-180,-356,-532).
REQ-018 Each cycle with regAddr<=16, slot[regAddr] (17 x 8 bit) SHALL capture memData at the clock edge.
REQ-019 FSM states IDLE, CLASSIFY, REPORT; IDLE->CLASSIFY on readen, CLASSIFY->REPORT, REPORT->IDLE unconditionally.
REQ-020 On the IDLE edge with readen=1, SHALL latch refAddr and 16-bit masks: bright[i]=(slot[i] > c+t), dark[i]=(slot[i] < c-t), c=slot[0], compared in 10-bit signed arithmetic (no 8-bit wrap).
REQ-021 In CLASSIFY SHALL compute corner = any of 16 circular windows of 9 consecutive bits all 1 in bright OR in dark; window wraps slot 16 to slot 1.
REQ-022 cornerValid SHALL be 1 exactly in REPORT (2 cycles after the readen cycle) with cornerFlag/cornerAddr stable; cornerFlag/cornerAddr SHALL hold until next REPORT.
REQ-023 Slot writes SHALL continue during CLASSIFY/REPORT without affecting the latched masks.
REQ-024 readen while CLASSIFY or REPORT SHALL be ignored and SHALL set overrun; readen and regAddr write on the same edge: masks use pre-write slot values.
REQ-025 Equal intensities (p=c+t or p=c-t) SHALL classify as neither bright nor dark.

Reset
REQ-026 nReset low SHALL immediately force state IDLE, memAddr=0, memRd=0, cornerValid=0, cornerFlag=0, cornerAddr=0, overrun=0, all slots=0, masks=0, cornerScore=0.
REQ-027 Reset mid-evaluation SHALL abort with no cornerValid pulse after release.

Configuration
REQ-028 Macro FD_SEGMENT_SCORE_EN: when defined, output cornerScore [11:0] SHALL equal sum over i=1..16 of |slot[i]-slot[0]|, latched at readen, valid with cornerValid, accumulated as slots are written (cleared on slot-0 write).
REQ-029 Without FD_SEGMENT_SCORE_EN the cornerScore port and accumulator SHALL not exist; all other behaviour identical.

Verification
REQ-030 c=100, slots 1..9=130, 10..16=100, t=20 -> cornerValid at readen+2, cornerFlag=1.
REQ-031 c=100, slots 1..8=130, rest 100 -> cornerFlag=0 (8 contiguous insufficient).
REQ-032 c=100, slots 13..16 and 1..5=60, rest 100 -> cornerFlag=1 (dark run wraps 16->1).
REQ-033 refAddr=543, adjNumber=1 -> memAddr=12, memRd=1 next cycle; adjNumber=17 -> memRd=0.
REQ-034 Second readen in CLASSIFY -> one cornerValid only, overrun=1 until nReset.
REQ-035 With FD_SEGMENT_SCORE_EN, c=0, all circle slots=255 -> cornerScore=4080, cornerFlag=1; nReset pulse mid-CLASSIFY -> no cornerValid, all outputs 0.

Source files
------------

// File: rtl/fd_segment_tester.sv
// FAST-9 segment test: fetches the centre and 16 circle pixels, classifies the circle
// against the centre, and reports one corner verdict per evaluation. Optional score: FD_SEGMENT_SCORE_EN.
module fd_segment_tester #(
  parameter logic [7:0] THRESHOLD = 8'd20,
  parameter int         IMG_WIDTH = 177
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [14:0] refAddr,
  input  logic [4:0]  adjNumber,
  input  logic [4:0]  regAddr,
  input  logic        readen,
  output logic [14:0] memAddr,
  output logic        memRd,
  input  logic [7:0]  memData,
  output logic        cornerValid,
  output logic        cornerFlag,
  output logic [14:0] cornerAddr,
  output logic        overrun
`ifdef FD_SEGMENT_SCORE_EN
  ,output logic [11:0] cornerScore
`endif
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, REPORT} state_t;

  state_t            state_q, state_d;
  logic [14:0]       memAddr_q, ref_q, cornerAddr_q;
  logic              memRd_q, cornerValid_q, cornerFlag_q, overrun_q;
  logic [16:0][7:0]  slot_q;
  logic [15:0]       bright_q, dark_q, bright_d, dark_d;
  logic              corner;

  // Circle offsets as row-pitch-scaled signed values, wrapped to the 15-bit address space.
  function automatic logic [14:0] circ_off(input logic [4:0] idx);
    int dx, dy;
    dx = 0; dy = 0;
    case (idx)
      5'd1:  begin dx =  0; dy = -3; end
      5'd2:  begin dx =  1; dy = -3; end
      5'd3:  begin dx =  2; dy = -2; end
      5'd4:  begin dx =  3; dy = -1; end
      5'd5:  begin dx =  3; dy =  0; end
      5'd6:  begin dx =  3; dy =  1; end
      5'd7:  begin dx =  2; dy =  2; end
      5'd8:  begin dx =  1; dy =  3; end
      5'd9:  begin dx =  0; dy =  3; end
      5'd10: begin dx = -1; dy =  3; end
      5'd11: begin dx = -2; dy =  2; end
      5'd12: begin dx = -3; dy =  1; end
      5'd13: begin dx = -3; dy =  0; end
      5'd14: begin dx = -3; dy = -1; end
      5'd15: begin dx = -2; dy = -2; end
      5'd16: begin dx = -1; dy = -3; end
      default: begin dx = 0; dy = 0; end
    endcase
    return 15'(dy * IMG_WIDTH + dx);
  endfunction

  // 10-bit signed compare so c+t above 255 and c-t below 0 never wrap.
  always_comb begin
    logic signed [9:0] c_s, hi, lo, p;
    bright_d = '0;
    dark_d   = '0;
    c_s = $signed({2'b00, slot_q[0]});
    hi  = c_s + $signed({2'b00, THRESHOLD});
    lo  = c_s - $signed({2'b00, THRESHOLD});
    for (int i = 1; i <= 16; i++) begin
      p = $signed({2'b00, slot_q[i]});
      bright_d[i-1] = p > hi;
      dark_d[i-1]   = p < lo;
    end
  end

  always_comb begin
    logic wb, wd;
    corner = 1'b0;
    for (int s = 0; s < 16; s++) begin
      wb = 1'b1;
      wd = 1'b1;
      for (int k = 0; k < 9; k++) begin
        wb = wb & bright_q[(s + k) % 16];
        wd = wd & dark_q[(s + k) % 16];
      end
      corner = corner | wb | wd;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (readen) state_d = CLASSIFY;
      CLASSIFY: state_d = REPORT;
      REPORT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= IDLE;
      memAddr_q     <= '0;
      memRd_q       <= 1'b0;
      slot_q        <= '0;
      bright_q      <= '0;
      dark_q        <= '0;
      ref_q         <= '0;
      cornerValid_q <= 1'b0;
      cornerFlag_q  <= 1'b0;
      cornerAddr_q  <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      memRd_q <= (adjNumber <= 5'd16);
      if (adjNumber <= 5'd16) memAddr_q <= refAddr + circ_off(adjNumber);
      if (regAddr <= 5'd16) slot_q[regAddr] <= memData;
      if (state_q == IDLE && readen) begin
        bright_q <= bright_d;
        dark_q   <= dark_d;
        ref_q    <= refAddr;
      end
      if (state_q != IDLE && readen) overrun_q <= 1'b1;
      cornerValid_q <= (state_q == CLASSIFY);
      if (state_q == CLASSIFY) begin
        cornerFlag_q <= corner;
        cornerAddr_q <= ref_q;
      end
    end
  end

`ifdef FD_SEGMENT_SCORE_EN
  logic [11:0] acc_q, score_q;
  logic [7:0]  absdiff;

  assign absdiff = (memData >= slot_q[0]) ? memData - slot_q[0] : slot_q[0] - memData;

  // Running SAD against the centre; the centre write restarts it.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      acc_q   <= '0;
      score_q <= '0;
    end else begin
      if (regAddr == 5'd0)       acc_q <= '0;
      else if (regAddr <= 5'd16) acc_q <= acc_q + {4'b0000, absdiff};
      if (state_q == IDLE && readen) score_q <= acc_q;
    end
  end

  assign cornerScore = score_q;
`endif

  assign memAddr     = memAddr_q;
  assign memRd       = memRd_q;
  assign cornerValid = cornerValid_q;
  assign cornerFlag  = cornerFlag_q;
  assign cornerAddr  = cornerAddr_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fd_segment_tester.sv
// Directed bench for fd_segment_tester; score checks compile in with FD_SEGMENT_SCORE_EN.
module tb_fd_segment_tester;

  logic        clock, nReset, readen, memRd, cornerValid, cornerFlag, overrun;
  logic [14:0] refAddr, memAddr, cornerAddr;
  logic [4:0]  adjNumber, regAddr;
  logic [7:0]  memData;
`ifdef FD_SEGMENT_SCORE_EN
  logic [11:0] cornerScore;
`endif

  int n_chk = 0;
  int n_pass = 0;

  fd_segment_tester dut (
    .clock(clock), .nReset(nReset), .refAddr(refAddr), .adjNumber(adjNumber),
    .regAddr(regAddr), .readen(readen), .memAddr(memAddr), .memRd(memRd),
    .memData(memData), .cornerValid(cornerValid), .cornerFlag(cornerFlag),
    .cornerAddr(cornerAddr), .overrun(overrun)
`ifdef FD_SEGMENT_SCORE_EN
    , .cornerScore(cornerScore)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Slot 0 = c; slot i = sel[i-1] ? on_v : off_v. Centre is written first.
  task automatic fill(input int c, input logic [15:0] sel, input int on_v, input int off_v);
    regAddr = 5'd0; memData = 8'(c);
    @(negedge clock);
    for (int i = 1; i <= 16; i++) begin
      regAddr = 5'(i);
      memData = sel[i-1] ? 8'(on_v) : 8'(off_v);
      @(negedge clock);
    end
    regAddr = 5'd31;
  endtask

  task automatic eval(input string tag, input logic [14:0] a, input logic exp_flag);
    refAddr = a; readen = 1'b1;
    @(negedge clock);
    readen = 1'b0;
    chk({tag, ".classify_nv"}, cornerValid, 0);
    @(negedge clock);
    chk({tag, ".valid"}, cornerValid, 1);
    chk({tag, ".flag"}, cornerFlag, exp_flag);
    chk({tag, ".addr"}, cornerAddr, a);
    @(negedge clock);
    chk({tag, ".valid_drop"}, cornerValid, 0);
    chk({tag, ".flag_hold"}, cornerFlag, exp_flag);
  endtask

  logic [14:0] ref_t [6] = '{15'd543, 15'd543, 15'd543, 15'd543, 15'd543, 15'd0};
  logic [4:0]  adj_t [6] = '{5'd1, 5'd17, 5'd0, 5'd8, 5'd16, 5'd1};
  logic [14:0] addr_t[6] = '{15'd12, 15'd12, 15'd543, 15'd1075, 15'd11, 15'd32237};
  logic        rd_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int seen;
    nReset = 1'b0; readen = 1'b0; refAddr = '0; adjNumber = 5'd31;
    regAddr = 5'd31; memData = '0;
    #12;
    chk("rst.memAddr", memAddr, 0);
    chk("rst.memRd", memRd, 0);
    chk("rst.valid", cornerValid, 0);
    chk("rst.flag", cornerFlag, 0);
    chk("rst.addr", cornerAddr, 0);
    chk("rst.overrun", overrun, 0);
    @(negedge clock);
    nReset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      refAddr = ref_t[i]; adjNumber = adj_t[i];
      @(negedge clock);
      chk($sformatf("fetch%0d.addr", i), memAddr, addr_t[i]);
      chk($sformatf("fetch%0d.rd", i), memRd, rd_t[i]);
    end
    adjNumber = 5'd31;

    fill(100, 16'h01FF, 130, 100); eval("run9_bright", 15'd1234, 1'b1);
    fill(100, 16'h00FF, 130, 100); eval("run8_bright", 15'd77, 1'b0);
    fill(100, 16'hF01F, 60, 100);  eval("run9_dark_wrap", 15'd32000, 1'b1);
    fill(100, 16'hFFFF, 120, 0);   eval("eq_bright", 15'd5, 1'b0);
    fill(100, 16'hFFFF, 121, 0);   eval("above_bright", 15'd6, 1'b1);
    fill(100, 16'hFFFF, 80, 0);    eval("eq_dark", 15'd7, 1'b0);
    fill(100, 16'hFFFF, 79, 0);    eval("below_dark", 15'd8, 1'b1);
    fill(10, 16'hFFFF, 0, 0);      eval("nowrap_low", 15'd9, 1'b0);
    fill(250, 16'hFFFF, 255, 0);   eval("nowrap_high", 15'd10, 1'b0);

    // Slot 9 written on the readen edge: masks must see the old value.
    fill(100, 16'h00FF, 130, 100);
    refAddr = 15'd300; readen = 1'b1; regAddr = 5'd9; memData = 8'd130;
    @(negedge clock);
    readen = 1'b0; regAddr = 5'd31;
    @(negedge clock);
    chk("samedge.valid", cornerValid, 1);
    chk("samedge.flag", cornerFlag, 0);
    @(negedge clock);
    eval("samedge_after", 15'd301, 1'b1);

`ifdef FD_SEGMENT_SCORE_EN
    fill(0, 16'hFFFF, 255, 0);
    eval("score", 15'd400, 1'b1);
    chk("score.value", cornerScore, 4080);
`endif

    chk("overrun.before", overrun, 0);
    refAddr = 15'd500; readen = 1'b1;
    @(negedge clock);
    @(negedge clock);
    readen = 1'b0;
    chk("overrun.valid", cornerValid, 1);
    chk("overrun.addr", cornerAddr, 500);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (cornerValid) seen++;
    end
    chk("overrun.single_pulse", seen, 0);
    chk("overrun.sticky", overrun, 1);

    // Reset in CLASSIFY: outputs clear at once and the pulse never comes.
    fill(100, 16'h01FF, 130, 100);
    refAddr = 15'd600; readen = 1'b1;
    @(negedge clock);
    readen = 1'b0;
    #2 nReset = 1'b0;
    #1;
    chk("midrst.flag", cornerFlag, 0);
    chk("midrst.addr", cornerAddr, 0);
    chk("midrst.overrun", overrun, 0);
    chk("midrst.valid", cornerValid, 0);
`ifdef FD_SEGMENT_SCORE_EN
    chk("midrst.score", cornerScore, 0);
`endif
    @(negedge clock);
    nReset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (cornerValid) seen++;
    end
    chk("midrst.no_pulse", seen, 0);
    eval("post_rst_slots_zero", 15'd700, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
